div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Sequencer between the execute stage and the iterative divider.
- Accepts RISC-V M-extension divide requests (DIV/DIVU/REM/REMU) and resolves the architectural special cases (divide-by-zero, signed overflow) locally in one cycle.
- Otherwise launches the divider, tracks its busy handshake, and returns the result to writeback.
- Drives the pipeline stall while an operation is outstanding.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a divide op
- req_ready  out  1  block can accept a request
- req_funct3  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU
- req_rs1  in  XLEN  dividend
- req_rs2  in  XLEN  divisor
- req_rd  in  5  destination register tag
- flush  in  1  kill in-flight op (branch redirect/trap)
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_data  out  XLEN  quotient or remainder
- resp_rd  out  5  destination tag of resp_data
- stall  out  1  hold upstream pipeline
- div_start  out  1  one-cycle launch pulse to divider
- div_dividend  out  XLEN  operand to divider
- div_divisor  out  XLEN  operand to divider
- div_op  out  3  req_funct3, passed verbatim, held stable while the divider is busy
- div_result  in  XLEN  divider output
- div_busy  in  1  divider running

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; div_start=0; stall=0; resp_data=0; resp_rd=0; operand/op registers=0.
- Operand and tag latch on the accept cycle (req_valid & req_ready). The div_* outputs are driven from the latched registers.
- States: IDLE, SPECIAL, LAUNCH, WAIT_HI, WAIT_LO, RESP, DRAIN.
- IDLE: req_ready=1. On accept:
  - divisor==0, or signed op (DIV/REM) with rs1=0x80000000 and rs2=0xFFFFFFFF -> SPECIAL.
  - Otherwise -> LAUNCH.
- SPECIAL (1 cycle): compute the result, then -> RESP.
  - Divide-by-zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1.
  - Overflow: DIV = 0x80000000; REM = 0.
  - Total latency accept -> resp_valid is 2 cycles.
- LAUNCH: div_start=1 for exactly one cycle, then -> WAIT_HI.
- WAIT_HI: wait for div_busy=1, then -> WAIT_LO. If busy is still not seen after 2 cycles, treat as already complete and -> WAIT_LO.
- WAIT_LO: on the first cycle div_busy=0, capture div_result into resp_data, then -> RESP.
- RESP: resp_valid=1; resp_data and resp_rd held stable until resp_ready. On the resp_valid & resp_ready cycle -> IDLE. A new request is accepted no earlier than the next cycle (no same-cycle turnaround).
- stall = req_valid & ~req_ready, plus 1 in every state except IDLE.
- req_ready=1 only in IDLE.
- flush:
  - In SPECIAL or RESP: drop the result; resp_valid=0 next cycle; -> IDLE.
  - In LAUNCH, WAIT_HI or WAIT_LO: -> DRAIN, discarding the result.
  - In IDLE: flush has priority over accept in the same cycle; nothing is latched.
- DRAIN: the divider ignores start while busy, so the block waits until div_busy=0 (and busy has been seen or the 2-cycle window has elapsed). Then -> IDLE. req_ready=0 and stall=1 while in DRAIN.
- resp_ready held low: the block stays in RESP indefinitely, with no further divider activity.
- Reset mid-operation: outputs return to reset values immediately. A divider left busy is handled because IDLE checks that div_busy=0 before LAUNCH; if busy, the block waits in IDLE with req_ready=0.
- No arithmetic beyond the special-case compare and constant selection; all widths XLEN.

Test Plan:
- DIVU 100/7, rd=5 -> div_start pulses once, div_op=101. After divider busy falls, resp_valid=1, resp_data=14, resp_rd=5. stall=1 throughout.
- DIV 0xFFFFFFF9(-7)/2 then REM same operands -> resp_data=0xFFFFFFFD(-3), then 0xFFFFFFFF(-1). One launch per op.
- DIV 0x80000000/0xFFFFFFFF -> no div_start; resp_valid 2 cycles after accept; resp_data=0x80000000. Same operands as REM -> resp_data=0.
- REMU 1234/0 -> resp_data=1234; DIVU 1234/0 -> resp_data=0xFFFFFFFF. div_start never asserted.
- Assert flush 5 cycles into WAIT_LO -> resp_valid never rises; block stays in DRAIN until div_busy=0, then req_ready=1. Next DIV 9/3 -> resp_data=3.
- Hold resp_ready=0 for 10 cycles in RESP -> resp_data stable; req_ready=0. Release -> accept-to-IDLE handshake in 1 cycle. Async rst_n pulse mid-WAIT_HI -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences RISC-V M-extension divides between execute and an iterative divider.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake from execute
//   req_funct3/rs1/rs2/rd           op (100 DIV,101 DIVU,110 REM,111 REMU), operands, dest tag
//   flush                           kill in-flight op
//   resp_valid/resp_ready           result handshake to writeback
//   resp_data/resp_rd               result and its dest tag
//   stall                           hold upstream pipeline
//   div_start/dividend/divisor/op   launch interface to the divider
//   div_result/div_busy             divider result and busy flag
module div_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            stall,
    output logic            div_start,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic [2:0]      div_op,
    input  logic [XLEN-1:0] div_result,
    input  logic            div_busy
);
    typedef enum logic [2:0] {IDLE, SPECIAL, LAUNCH, WAIT_HI, WAIT_LO, RESP, DRAIN} state_t;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t          r_state;
    logic [XLEN-1:0] r_a, r_b, r_data;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic [1:0]      r_cnt;
    logic            r_seen;
    logic            w_accept, w_special, w_window;
    logic [XLEN-1:0] w_special_data;
    // A divider still busy (e.g. after a reset mid-operation) must finish before a new launch.
    assign req_ready    = (r_state == IDLE) & ~div_busy;
    assign stall        = (req_valid & ~req_ready) | (r_state != IDLE);
    assign resp_valid   = r_state == RESP;
    assign div_start    = r_state == LAUNCH;
    assign resp_data    = r_data;
    assign resp_rd      = r_rd;
    assign div_dividend = r_a;
    assign div_divisor  = r_b;
    assign div_op       = r_op;
    assign w_accept     = req_valid & req_ready & ~flush;
    assign w_special    = (req_rs2 == '0) | (~req_funct3[0] & (req_rs1 == MIN) & (req_rs2 == '1));
    // funct3[1] selects remainder; a non-zero divisor here implies signed overflow.
    assign w_special_data = (r_b == '0) ? (r_op[1] ? r_a : '1) : (r_op[1] ? '0 : MIN);
    // Busy either observed or the 2-cycle launch window has elapsed.
    assign w_window     = r_seen | (r_cnt == 2'd2);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
        end else begin
            if (r_state == WAIT_HI || r_state == DRAIN) begin
                if (div_busy) r_seen <= 1'b1;
                if (r_cnt != 2'd2) r_cnt <= r_cnt + 2'd1;
            end
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a     <= req_rs1;
                    r_b     <= req_rs2;
                    r_op    <= req_funct3;
                    r_rd    <= req_rd;
                    r_cnt   <= '0;
                    r_seen  <= 1'b0;
                    r_state <= w_special ? SPECIAL : LAUNCH;
                end
                SPECIAL: begin
                    if (!flush) r_data <= w_special_data;
                    r_state <= flush ? IDLE : RESP;
                end
                LAUNCH:  r_state <= flush ? DRAIN : WAIT_HI;
                WAIT_HI: r_state <= flush ? DRAIN : ((div_busy || r_cnt == 2'd1) ? WAIT_LO : WAIT_HI);
                WAIT_LO: begin
                    if (!flush && !div_busy) r_data <= div_result;
                    r_state <= flush ? DRAIN : (div_busy ? WAIT_LO : RESP);
                end
                RESP:    r_state <= (flush || resp_ready) ? IDLE : RESP;
                DRAIN:   r_state <= (!div_busy && w_window) ? IDLE : DRAIN;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
